// File: rtl/riscv_ctrl_fsm_pkg.sv
// rtl/riscv_ctrl_fsm_pkg.sv - shared state, trap and decoder-select types for the control sequencer
package riscv_ctrl_fsm_pkg;

  localparam int CTRL_TIMEOUT_DEFAULT = 255;

  localparam int WB_SEL_W  = 2;
  localparam int PC_SEL_W  = 2;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TRAP_NONE        = 2'd0,
    TRAP_ILLEGAL     = 2'd1,
    TRAP_MISALIGN    = 2'd2,
    TRAP_BUS_TIMEOUT = 2'd3
  } trap_cause_e;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_PLUS4    = 2'd0,
    PC_ALU      = 2'd1,
    PC_B_TARGET = 2'd2
  } pc_sel_e;

  localparam logic RF_WRITE  = 1'b1;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/riscv_ctrl_fsm_wait_timer.sv
// rtl/riscv_ctrl_fsm_wait_timer.sv - ack wait counter shared by the fetch and data-access waits
module riscv_wait_timer
  import riscv_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CTRL_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// rtl/riscv_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and instret
module riscv_ctrl_fsm
  import riscv_ctrl_fsm_pkg::*;
#(
  parameter int                     WORD_LENGTH    = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC       = '0,
  parameter int                     TIMEOUT_CYCLES = CTRL_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [WORD_LENGTH-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [WORD_LENGTH-1:0] imem_rdata_i,
  output logic [WORD_LENGTH-1:0] ir_o,
  input  logic                   dec_valid_i,
  input  logic [WB_SEL_W-1:0]    wb_sel_i,
  input  logic                   rf_wen_i,
  input  logic                   mem_wen_i,
  input  logic [PC_SEL_W-1:0]    pc_sel_i,
  input  logic [WORD_LENGTH-1:0] alu_result_i,
  input  logic                   br_taken_i,
  input  logic [WORD_LENGTH-1:0] br_target_i,
  output logic                   alu_lat_o,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  input  logic                   dmem_ack_i,
  output logic                   rf_we_o,
  output logic [WORD_LENGTH-1:0] pc_o,
  output logic [WORD_LENGTH-1:0] instret_o,
  output logic                   trap_o,
  output logic [1:0]             trap_cause_o,
  output logic [STATE_W-1:0]     state_o
);

  ctrl_state_e              r_state;
  ctrl_state_e              w_next_state;
  trap_cause_e              r_cause;
  trap_cause_e              w_next_cause;
  logic [WORD_LENGTH-1:0]   r_pc;
  logic [WORD_LENGTH-1:0]   r_ir;
  logic [WORD_LENGTH-1:0]   r_instret;
  logic [WORD_LENGTH-1:0]   w_pc_plus4;
  logic [WORD_LENGTH-1:0]   w_next_pc;
  logic                     w_timer_en;
  logic                     w_timer_clr;
  logic                     w_expired;

  riscv_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  always_comb begin
    w_pc_plus4 = r_pc + WORD_LENGTH'(4);
    w_next_pc  = w_pc_plus4;
    case (pc_sel_i)
      PC_ALU:      w_next_pc = alu_result_i;
      PC_B_TARGET: w_next_pc = br_taken_i ? br_target_i : w_pc_plus4;
      default:     w_next_pc = w_pc_plus4;
    endcase
  end

  // Ack in the expiry cycle takes priority over the timeout trap.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    w_timer_en   = 1'b0;
    case (r_state)
      FETCH: begin
        if (imem_ack_i) begin
          w_next_state = DECODE;
        end else if (w_expired) begin
          w_next_state = TRAP;
          w_next_cause = TRAP_BUS_TIMEOUT;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      DECODE: begin
        if (!dec_valid_i) begin
          w_next_state = TRAP;
          w_next_cause = TRAP_ILLEGAL;
        end else begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (mem_wen_i == MEM_WRITE || wb_sel_i == WB_MEM) begin
          w_next_state = MEM;
        end else begin
          w_next_state = WB;
        end
      end
      MEM: begin
        if (dmem_ack_i) begin
          w_next_state = WB;
        end else if (w_expired) begin
          w_next_state = TRAP;
          w_next_cause = TRAP_BUS_TIMEOUT;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      WB: begin
        if (w_next_pc[1:0] != 2'b00) begin
          w_next_state = TRAP;
          w_next_cause = TRAP_MISALIGN;
        end else begin
          w_next_state = FETCH;
        end
      end
      TRAP:    w_next_state = TRAP;
      default: w_next_state = FETCH;
    endcase
  end

  assign w_timer_clr = (w_next_state != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_cause   <= TRAP_NONE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_next_cause;
      if (r_state == FETCH && imem_ack_i) begin
        r_ir <= imem_rdata_i;
      end
      if (r_state == WB && w_next_state == FETCH) begin
        r_pc      <= w_next_pc;
        r_instret <= r_instret + WORD_LENGTH'(1);
      end
    end
  end

  // Requests are qualified by rst_n so an access is dropped the moment reset asserts.
  assign imem_req_o   = rst_n && (r_state == FETCH);
  assign imem_addr_o  = r_pc;
  assign dmem_req_o   = rst_n && (r_state == MEM);
  assign dmem_we_o    = rst_n && (r_state == MEM) && (mem_wen_i == MEM_WRITE);
  assign alu_lat_o    = (r_state == EXEC);
  assign rf_we_o      = (r_state == WB) && (rf_wen_i == RF_WRITE);
  assign ir_o         = r_ir;
  assign pc_o         = r_pc;
  assign instret_o    = r_instret;
  assign trap_o       = (r_state == TRAP);
  assign trap_cause_o = r_cause;
  assign state_o      = r_state;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// tb/tb_riscv_ctrl_fsm.sv - randomized self-checking bench for riscv_ctrl_fsm
module tb_riscv_ctrl_fsm;
  import riscv_ctrl_fsm_pkg::*;

  localparam int          W   = 32;
  localparam int          TMO = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o, imem_ack_i, dec_valid_i, rf_wen_i, mem_wen_i, br_taken_i;
  logic        alu_lat_o, dmem_req_o, dmem_we_o, dmem_ack_i, rf_we_o, trap_o;
  logic [31:0] imem_addr_o, imem_rdata_i, ir_o, alu_result_i, br_target_i, pc_o, instret_o;
  logic [1:0]  wb_sel_i, pc_sel_i, trap_cause_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  riscv_ctrl_fsm #(.WORD_LENGTH(W), .RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .ir_o(ir_o), .dec_valid_i(dec_valid_i),
    .wb_sel_i(wb_sel_i), .rf_wen_i(rf_wen_i), .mem_wen_i(mem_wen_i), .pc_sel_i(pc_sel_i),
    .alu_result_i(alu_result_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .alu_lat_o(alu_lat_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_ack_i(dmem_ack_i), .rf_we_o(rf_we_o), .pc_o(pc_o), .instret_o(instret_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, dreq, dwe, alat, rfwe, trap;
    logic [1:0]  cause;
    logic [31:0] addr, pc, ir, instret;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ireq_cnt = 0, dreq_cnt = 0, dwe_cnt = 0, rfwe_cnt = 0;
  logic [31:0] m_pc, m_ir, m_instret;
  logic        m_trap;
  logic [1:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Per-cycle compare against the trace queued by the transaction driver.
  initial begin : cmp
    exp_t e, a;
    forever begin
      @(negedge clk);
      #2;
      ireq_cnt += int'(imem_req_o);
      dreq_cnt += int'(dmem_req_o);
      dwe_cnt  += int'(dmem_we_o);
      rfwe_cnt += int'(rf_we_o);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {state_o, imem_req_o, dmem_req_o, dmem_we_o, alu_lat_o, rf_we_o, trap_o,
             trap_cause_o, imem_addr_o, pc_o, ir_o, instret_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_trace t=%0t: got %h expected %h", $time, a, e);
        end
      end
    end
  end

  function automatic exp_t base(input ctrl_state_e s);
    exp_t e;
    e = '0;
    e.st = s; e.trap = m_trap; e.cause = m_cause;
    e.addr = m_pc; e.pc = m_pc; e.ir = m_ir; e.instret = m_instret;
    return e;
  endfunction

  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ir = '0; m_instret = '0; m_trap = 1'b0; m_cause = TRAP_NONE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic trap_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base(TRAP);
      imem_ack_i = 1'($urandom); dmem_ack_i = 1'($urandom);
      cyc(e);
    end
  endtask

  // One instruction: wf/wm are ack wait cycles (>=TMO means never acked; wm<0 stalls in MEM).
  task automatic run_instr(input logic [31:0] rdata, input int wf, input logic valid,
                           input logic [1:0] wbsel, input logic rfw, input logic memw,
                           input logic [1:0] pcsel, input logic [31:0] alu, input logic brt,
                           input logic [31:0] btgt, input int wm);
    exp_t        e;
    logic [31:0] p4, nxt;
    dec_valid_i = valid; wb_sel_i = wbsel; rf_wen_i = rfw; mem_wen_i = memw;
    pc_sel_i = pcsel; alu_result_i = alu; br_taken_i = brt; br_target_i = btgt;
    for (int c = 0; ; c++) begin
      e = base(FETCH); e.ireq = 1'b1;
      imem_ack_i = (c == wf);
      imem_rdata_i = (c == wf) ? rdata : $urandom;
      dmem_ack_i = 1'($urandom);
      cyc(e);
      if (c == wf) begin m_ir = rdata; break; end
      if (c == TMO - 1) begin m_trap = 1'b1; m_cause = TRAP_BUS_TIMEOUT; return; end
    end
    e = base(DECODE);
    imem_ack_i = 1'($urandom); dmem_ack_i = 1'($urandom);
    cyc(e);
    if (!valid) begin m_trap = 1'b1; m_cause = TRAP_ILLEGAL; return; end
    e = base(EXEC); e.alat = 1'b1;
    imem_ack_i = 1'($urandom);
    cyc(e);
    if (memw || wbsel == WB_MEM) begin
      for (int c = 0; ; c++) begin
        e = base(MEM); e.dreq = 1'b1; e.dwe = memw;
        dmem_ack_i = (wm >= 0) && (c == wm);
        imem_ack_i = 1'($urandom);
        cyc(e);
        if (wm < 0 && c == 1) return;
        if (wm >= 0 && c == wm) break;
        if (c == TMO - 1) begin m_trap = 1'b1; m_cause = TRAP_BUS_TIMEOUT; return; end
      end
    end
    e = base(WB); e.rfwe = rfw;
    imem_ack_i = 1'($urandom); dmem_ack_i = 1'($urandom);
    cyc(e);
    p4 = m_pc + 32'd4;
    if (pcsel == PC_ALU) nxt = alu;
    else if (pcsel == PC_B_TARGET) nxt = brt ? btgt : p4;
    else nxt = p4;
    if (nxt[1:0] != 2'b00) begin
      m_trap = 1'b1; m_cause = TRAP_MISALIGN;
    end else begin
      m_pc = nxt; m_instret = m_instret + 32'd1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
  endfunction

  initial begin : drv
    imem_ack_i = 0; imem_rdata_i = 0; dec_valid_i = 0; wb_sel_i = 0; rf_wen_i = 0;
    mem_wen_i = 0; pc_sel_i = 0; alu_result_i = 0; br_taken_i = 0; br_target_i = 0;
    dmem_ack_i = 0;
    model_reset();
    #2;
    chk("reset_state", 32'(state_o), 32'(FETCH));
    chk("reset_imem_req", 32'(imem_req_o), 0);
    chk("reset_pc", pc_o, RPC);
    chk("reset_ir_instret", ir_o | instret_o, 0);
    chk("reset_trap", {29'd0, trap_o, trap_cause_o}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    rfwe_cnt = 0;
    run_instr(32'h00500093, 0, 1, WB_ALU, 1, 0, PC_PLUS4, 32'h5, 0, 0, 0);
    chk("addi_pc", pc_o, 32'h4);
    chk("addi_instret", instret_o, 32'd1);
    chk("addi_rf_we_cycles", rfwe_cnt, 1);

    dreq_cnt = 0; dwe_cnt = 0; rfwe_cnt = 0;
    run_instr(32'h0020a023, 0, 1, WB_ALU, 0, 1, PC_PLUS4, 32'h100, 0, 0, 3);
    chk("sw_dmem_req_cycles", dreq_cnt, 4);
    chk("sw_dmem_we_cycles", dwe_cnt, 4);
    chk("sw_rf_we_cycles", rfwe_cnt, 0);
    chk("sw_pc", pc_o, 32'h8);

    run_instr(32'h02208063, 1, 1, WB_ALU, 0, 0, PC_B_TARGET, 32'h0, 1, 32'h40, 0);
    chk("beq_taken_pc", pc_o, 32'h40);
    run_instr(32'h02208063, 2, 1, WB_ALU, 0, 0, PC_B_TARGET, 32'h0, 0, 32'h80, 0);
    chk("beq_untaken_pc", pc_o, 32'h44);
    run_instr(32'h0bc000ef, 0, 1, WB_PC4, 1, 0, PC_ALU, 32'h102, 0, 0, 0);
    chk("jal_trap", 32'(trap_o), 1);
    chk("jal_cause", 32'(trap_cause_o), 32'(TRAP_MISALIGN));
    chk("jal_pc_held", pc_o, 32'h44);
    chk("jal_instret_held", instret_o, 32'd4);
    trap_cycles(4);
    do_reset();

    run_instr(32'hFFFFFFFF, 1, 0, WB_ALU, 1, 0, PC_PLUS4, 0, 0, 0, 0);
    ireq_cnt = 0;
    trap_cycles(6);
    chk("illegal_cause", 32'(trap_cause_o), 32'(TRAP_ILLEGAL));
    chk("illegal_ir", ir_o, 32'hFFFFFFFF);
    chk("illegal_no_fetch", ireq_cnt, 0);
    do_reset();

    ireq_cnt = 0;
    run_instr(32'h1, TMO, 1, WB_ALU, 0, 0, PC_PLUS4, 0, 0, 0, 0);
    trap_cycles(2);
    chk("fetch_timeout_req_cycles", ireq_cnt, TMO);
    chk("fetch_timeout_cause", 32'(trap_cause_o), 32'(TRAP_BUS_TIMEOUT));
    do_reset();

    ireq_cnt = 0;
    run_instr(32'h00000013, TMO - 1, 1, WB_ALU, 1, 0, PC_PLUS4, 0, 0, 0, 0);
    chk("late_ack_req_cycles", ireq_cnt, TMO);
    chk("late_ack_instret", instret_o, 32'd1);

    run_instr(32'h0000a103, 0, 1, WB_MEM, 1, 0, PC_PLUS4, 32'h200, 0, 0, TMO);
    trap_cycles(1);
    chk("mem_timeout_cause", 32'(trap_cause_o), 32'(TRAP_BUS_TIMEOUT));
    do_reset();

    run_instr(32'h00000013, 0, 1, WB_ALU, 0, 0, PC_PLUS4, 0, 0, 0, 0);
    run_instr(32'h0000a103, 0, 1, WB_MEM, 1, 0, PC_PLUS4, 32'h200, 0, 0, -1);
    #2;
    chk("mid_mem_req_before_reset", 32'(dmem_req_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req_dropped", 32'(dmem_req_o), 0);
    chk("mid_mem_pc_reset", pc_o, RPC);
    chk("mid_mem_state", 32'(state_o), 32'(FETCH));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    repeat (400) begin
      run_instr($urandom, rand_wait(), ($urandom_range(0, 19) != 0),
                2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                2'($urandom), rand_addr(), 1'($urandom), rand_addr(), rand_wait());
      if (m_trap) begin
        trap_cycles(int'($urandom_range(1, 3)));
        do_reset();
      end
    end

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
